dram_arbiter: RTL and testbench

Three-port arbiter sharing the single-port 512x512x8 image DRAM between the UART receive writer, the downsampling datapath and the UART transmit retriever. It replaces the registered address mux in the UART control path. It grants one requester at a time, with bounded bursts, drives the RAM address, data and write-enable from registers, and returns read data to the owning port with a fixed latency.

---
 rtl/dram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_dram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: three-port arbiter for the shared single-port 512x512x8 image
// DRAM. Ports: rx (UART receive writer), dp (downsampling datapath), tx (UART
// transmit retriever). One owner at a time, bursts capped at BURST_MAX beats,
// a mandatory one-cycle bubble between grants. The RAM address, data and
// write-enable are all driven from registers. Read data comes back two cycles
// after the beat, tagged to the port that issued it.
//
// Build option: define DRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (rx -> dp -> tx -> rx). Without it the arbiter uses fixed priority
// rx > dp > tx, and no pointer logic is built.
module dram_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rx,
  input  logic              req_dp,
  input  logic              req_tx,
  input  logic              we_rx,
  input  logic              we_dp,
  input  logic              we_tx,
  input  logic [ADDR_W-1:0] addr_rx,
  input  logic [ADDR_W-1:0] addr_dp,
  input  logic [ADDR_W-1:0] addr_tx,
  input  logic [DATA_W-1:0] wdata_rx,
  input  logic [DATA_W-1:0] wdata_dp,
  input  logic [DATA_W-1:0] wdata_tx,
  output logic              gnt_rx,
  output logic              gnt_dp,
  output logic              gnt_tx,
  output logic              rvalid_rx,
  output logic              rvalid_dp,
  output logic              rvalid_tx,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  // Beat counter is wide enough for BURST_MAX up to 256.
  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot port vectors use bit 0 = rx, bit 1 = dp, bit 2 = tx.
  state_t           state;
  state_t           state_nx;
  logic [2:0]       owner;
  logic [2:0]       owner_nx;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_nx;
  logic [CNT_W-1:0] beat_cnt_inc;
  logic [2:0]       gnt_vec;
  logic [2:0]       req_vec;
  logic [2:0]       pick;

  // Owner-selected beat fields.
  logic              own_req;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              beat;

  // Read-return pipeline: {valid, owner} per stage.
  logic       s1_valid;
  logic [2:0] s1_owner;
  logic       s2_valid;
  logic [2:0] s2_owner;
  logic [2:0] rvalid_vec;

  assign req_vec = {req_tx, req_dp, req_rx};

  assign gnt_rx = gnt_vec[0];
  assign gnt_dp = gnt_vec[1];
  assign gnt_tx = gnt_vec[2];

  assign rvalid_rx = rvalid_vec[0];
  assign rvalid_dp = rvalid_vec[1];
  assign rvalid_tx = rvalid_vec[2];

  // Lowest-index requester wins; returns zero when nobody is requesting.
  function automatic logic [2:0] pick_lowest(input logic [2:0] r);
    logic [2:0] p;
    p = 3'b000;
    if (r[0]) begin
      p = 3'b001;
    end else if (r[1]) begin
      p = 3'b010;
    end else if (r[2]) begin
      p = 3'b100;
    end else begin
      p = 3'b000;
    end
    return p;
  endfunction

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  // One-hot port where the next search starts; rx after reset.
  logic [2:0] rr_ptr;
  logic [2:0] req_rot;
  logic [2:0] pick_rot;

  // Rotate the request vector so the search start sits in bit 0, pick the
  // lowest, then rotate the winner back into port order.
  always_comb begin
    req_rot = req_vec;
    pick    = 3'b000;
    case (rr_ptr)
      3'b010: begin
        req_rot  = {req_vec[0], req_vec[2], req_vec[1]};
        pick_rot = pick_lowest(req_rot);
        pick     = {pick_rot[1], pick_rot[0], pick_rot[2]};
      end
      3'b100: begin
        req_rot  = {req_vec[1], req_vec[0], req_vec[2]};
        pick_rot = pick_lowest(req_rot);
        pick     = {pick_rot[0], pick_rot[2], pick_rot[1]};
      end
      default: begin
        req_rot  = req_vec;
        pick_rot = pick_lowest(req_rot);
        pick     = pick_rot;
      end
    endcase
  end

  // Advance the pointer to the port after the winner on every grant entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 3'b001;
    end else if (state == IDLE && (|req_vec)) begin
      rr_ptr <= {pick[1:0], pick[2]};
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
`else
  // Fixed priority rx > dp > tx.
  always_comb begin
    pick = pick_lowest(req_vec);
  end
`endif

  // Route the current owner's request fields to the beat datapath.
  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_addr  = {ADDR_W{1'b0}};
    own_wdata = {DATA_W{1'b0}};
    case (owner)
      3'b001: begin
        own_req   = req_rx;
        own_we    = we_rx;
        own_addr  = addr_rx;
        own_wdata = wdata_rx;
      end
      3'b010: begin
        own_req   = req_dp;
        own_we    = we_dp;
        own_addr  = addr_dp;
        own_wdata = wdata_dp;
      end
      3'b100: begin
        own_req   = req_tx;
        own_we    = we_tx;
        own_addr  = addr_tx;
        own_wdata = wdata_tx;
      end
      default: begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_addr  = {ADDR_W{1'b0}};
        own_wdata = {DATA_W{1'b0}};
      end
    endcase
  end

  // A beat is any granted cycle in which the owner keeps its request high.
  assign beat         = (state == GRANT) && own_req;
  assign beat_cnt_inc = beat_cnt + 9'd1;

  // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    beat_cnt_nx = beat_cnt;
    case (state)
      IDLE: begin
        if (|req_vec) begin
          state_nx    = GRANT;
          owner_nx    = pick;
          beat_cnt_nx = 9'd0;
        end else begin
          state_nx    = IDLE;
          owner_nx    = 3'b000;
          beat_cnt_nx = 9'd0;
        end
      end
      GRANT: begin
        if (!own_req) begin
          // Owner let go: bubble, then re-arbitrate.
          state_nx    = IDLE;
          owner_nx    = 3'b000;
          beat_cnt_nx = 9'd0;
        end else if (beat_cnt_inc == BURST_LIM) begin
          // Burst cap reached on this beat: forced release.
          state_nx    = IDLE;
          owner_nx    = 3'b000;
          beat_cnt_nx = 9'd0;
        end else begin
          state_nx    = GRANT;
          owner_nx    = owner;
          beat_cnt_nx = beat_cnt_inc;
        end
      end
      default: begin
        state_nx    = IDLE;
        owner_nx    = 3'b000;
        beat_cnt_nx = 9'd0;
      end
    endcase
  end

  // FSM state, owner, beat counter and the registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 3'b000;
      beat_cnt <= 9'd0;
      gnt_vec  <= 3'b000;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      beat_cnt <= beat_cnt_nx;
      gnt_vec  <= (state_nx == GRANT) ? owner_nx : 3'b000;
    end
  end

  // RAM interface registers; address and data hold between beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr <= {ADDR_W{1'b0}};
      ram_data <= {DATA_W{1'b0}};
      ram_wren <= 1'b0;
    end else if (beat) begin
      ram_addr <= own_addr;
      ram_data <= own_wdata;
      ram_wren <= own_we;
    end else begin
      ram_wren <= 1'b0;
    end
  end

  // Read-return pipeline; keeps running across grant changes so an earlier
  // owner still gets its data after losing the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_owner   <= 3'b000;
      s2_valid   <= 1'b0;
      s2_owner   <= 3'b000;
      rvalid_vec <= 3'b000;
    end else begin
      s1_valid   <= beat && !own_we;
      s1_owner   <= owner;
      s2_valid   <= s1_valid;
      s2_owner   <= s1_owner;
      rvalid_vec <= s2_valid ? s2_owner : 3'b000;
    end
  end

  // Capture RAM output for the read whose address the RAM latched last edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= {DATA_W{1'b0}};
    end else if (s2_valid) begin
      rdata <= ram_q;
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed scenarios plus randomized traffic for
// dram_arbiter, checked every cycle against a transaction-level reference
// (owner / beat count / pending-read queue / reference memory).
module tb_dram_arbiter;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 8;
  localparam int BURST_MAX = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        req = 3'b000;
  logic [2:0]        we  = 3'b000;
  logic [ADDR_W-1:0] addr  [3];
  logic [DATA_W-1:0] wdata [3];

  logic              gnt_rx, gnt_dp, gnt_tx;
  logic              rvalid_rx, rvalid_dp, rvalid_tx;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  // Environment RAM: registered address/data/we, unregistered q.
  bit [7:0]  ram_mem [0:262143];
  bit [17:0] ram_raddr;

  // Reference state.
  bit [7:0]  ref_mem [0:262143];
  typedef struct {
    int       due;
    int       port;
    bit [7:0] data;
  } rd_t;
  rd_t rdq[$];
  int        cyc;
  bit        m_grant;
  int        m_owner;
  int        m_beats;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
  int        m_ptr;
`endif
  bit        exp_wren;
  bit [17:0] exp_addr;
  bit [7:0]  exp_data;

  int n_checks = 0;
  int n_errors = 0;

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .req_rx(req[0]), .req_dp(req[1]), .req_tx(req[2]),
    .we_rx(we[0]), .we_dp(we[1]), .we_tx(we[2]),
    .addr_rx(addr[0]), .addr_dp(addr[1]), .addr_tx(addr[2]),
    .wdata_rx(wdata[0]), .wdata_dp(wdata[1]), .wdata_tx(wdata[2]),
    .gnt_rx(gnt_rx), .gnt_dp(gnt_dp), .gnt_tx(gnt_tx),
    .rvalid_rx(rvalid_rx), .rvalid_dp(rvalid_dp), .rvalid_tx(rvalid_tx),
    .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // RAM model: inputs captured at the clock edge.
  always @(posedge clk) begin
    ram_raddr <= ram_addr;
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
  end
  assign ram_q = ram_mem[ram_raddr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_grant  = 1'b0;
    m_owner  = 0;
    m_beats  = 0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    m_ptr    = 0;
`endif
    exp_wren = 1'b0;
    exp_addr = 18'd0;
    exp_data = 8'd0;
    rdq.delete();
  endtask

  function automatic int choose();
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) begin
      if (req[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    end
`else
    for (int k = 0; k < 3; k++) begin
      if (req[k]) return k;
    end
`endif
    return -1;
  endfunction

  // Apply the arbitration rules to the inputs seen at this clock edge.
  task automatic model_edge();
    int  p;
    rd_t e;
    cyc++;
    exp_wren = 1'b0;
    if (!m_grant) begin
      p = choose();
      if (p >= 0) begin
        m_grant = 1'b1;
        m_owner = p;
        m_beats = 0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        m_ptr   = (p + 1) % 3;
`endif
      end
    end else if (req[m_owner]) begin
      exp_wren = we[m_owner];
      exp_addr = addr[m_owner];
      exp_data = wdata[m_owner];
      if (we[m_owner]) begin
        ref_mem[addr[m_owner]] = wdata[m_owner];
      end else begin
        e.due  = cyc + 2;
        e.port = m_owner;
        e.data = ref_mem[addr[m_owner]];
        rdq.push_back(e);
      end
      m_beats++;
      if (m_beats == BURST_MAX) m_grant = 1'b0;
    end else begin
      m_grant = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [2:0] eg;
    logic [2:0] ev;
    logic [7:0] ed;
    eg = m_grant ? 3'(3'b001 << m_owner) : 3'b000;
    ev = 3'b000;
    ed = 8'd0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      ev = 3'(3'b001 << rdq[0].port);
      ed = rdq[0].data;
      void'(rdq.pop_front());
    end
    check_eq("gnt", 32'({gnt_tx, gnt_dp, gnt_rx}), 32'(eg));
    check_eq("ram_wren", 32'(ram_wren), 32'(exp_wren));
    check_eq("ram_addr", 32'(ram_addr), 32'(exp_addr));
    check_eq("ram_data", 32'(ram_data), 32'(exp_data));
    check_eq("rvalid", 32'({rvalid_tx, rvalid_dp, rvalid_rx}), 32'(ev));
    if (ev != 3'b000) check_eq("rdata", 32'(rdata), 32'(ed));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gnt"}, 32'({gnt_tx, gnt_dp, gnt_rx}), 32'd0);
    check_eq({tag, "_rvalid"}, 32'({rvalid_tx, rvalid_dp, rvalid_rx}), 32'd0);
    check_eq({tag, "_ram_wren"}, 32'(ram_wren), 32'd0);
    check_eq({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check_eq({tag, "_ram_data"}, 32'(ram_data), 32'd0);
    check_eq({tag, "_rdata"}, 32'(rdata), 32'd0);
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [17:0] a, input logic [7:0] d);
    req[p]   = r;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  initial begin
    int run;
    int max_run;
    for (int p = 0; p < 3; p++) begin
      addr[p]  = 18'd0;
      wdata[p] = 8'd0;
    end
    cyc = 0;
    model_reset();

    // Power-on reset.
    rst = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All three request at once: rx first, then dp once rx lets go.
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 18'(p), 8'd0);
    step();
    check_eq("first_gnt_rx", 32'({gnt_tx, gnt_dp, gnt_rx}), 32'd1);
    step();
    step();
    req[0] = 1'b0;
    step();
    step();
    check_eq("second_gnt_dp", 32'({gnt_tx, gnt_dp, gnt_rx}), 32'd2);
    repeat (4) step();
    req = 3'b000;
    repeat (4) step();

    // rx writes 0xA5 to the top address, then tx reads it back.
    set_port(0, 1'b1, 1'b1, 18'h3FFFF, 8'hA5);
    step();
    step();
    req[0] = 1'b0;
    step();
    set_port(2, 1'b1, 1'b0, 18'h3FFFF, 8'h00);
    step();
    step();
    req[2] = 1'b0;
    repeat (4) step();

    // Seed 0x00100, then dp reads it as its last beat while tx waits.
    set_port(0, 1'b1, 1'b1, 18'h00100, 8'h5C);
    step();
    step();
    req[0] = 1'b0;
    step();
    set_port(1, 1'b1, 1'b0, 18'h00100, 8'h00);
    set_port(2, 1'b1, 1'b0, 18'h00020, 8'h00);
    step();
    step();
    req[1] = 1'b0;
    repeat (6) step();
    req = 3'b000;
    repeat (4) step();

    // Burst cap: dp streams reads for 60 cycles while tx keeps requesting.
    set_port(2, 1'b1, 1'b0, 18'h00030, 8'h00);
    req[1]  = 1'b1;
    we[1]   = 1'b0;
    run     = 0;
    max_run = 0;
    for (int c = 0; c < 60; c++) begin
      addr[1] = 18'(c);
      step();
      if (gnt_dp) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check_eq("burst_len", 32'(max_run), 32'(BURST_MAX));
    req = 3'b000;
    repeat (4) step();

    // Idle: no requests for 100 cycles.
    for (int c = 0; c < 100; c++) begin
      step();
      if (ram_wren || gnt_rx || gnt_dp || gnt_tx) check_eq("idle_quiet", 32'd1, 32'd0);
    end

    // Reset in the middle of a tx read burst with reads in flight.
    set_port(2, 1'b1, 1'b0, 18'h00010, 8'h00);
    repeat (3) step();
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    req = 3'b000;
    rst = 1'b0;
    repeat (6) step();

    // Randomized traffic with sticky requests over a small address window.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 3; p++) begin
        if (req[p]) begin
          if ($urandom_range(0, 7) == 0) req[p] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[p] = 1'b1;
        end
        we[p]    = 1'($urandom_range(0, 1));
        addr[p]  = ($urandom_range(0, 15) == 0) ? 18'h3FFFF : 18'($urandom_range(0, 7));
        wdata[p] = 8'($urandom);
      end
      step();
    end
    req = 3'b000;
    repeat (4) step();
    check_eq("rd_queue_empty", 32'(rdq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
